// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, flush and bubble gating; optional PIPE_STAGE_SKID_STATS_EN adds stall/bubble counters.
// Latency: 1 cycle from in_fire to out_valid. Backpressure: in_ready is registered, so out_ready never reaches in_ready combinationally.
module pipe_stage_skid #(
   parameter int                WIDTH    = 64,
   parameter int                CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic                in_ready_q;
   logic [WIDTH-1:0]    m_data, s_data;
   logic [CTRL_W-1:0]   m_ctrl, s_ctrl;
   logic                m_vld;
   logic                in_fire, out_fire;
   logic                load_m_in, load_m_s, load_s;

   assign m_vld     = (state != EMPTY);
   assign in_ready  = in_ready_q;
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = m_vld & out_ready;

   assign out_valid = m_vld;
   assign out_data  = m_data;
   // Bubble gating: an invalid head can never leak RegWrite/halt downstream.
   assign out_ctrl  = m_vld ? m_ctrl : CTRL_RST;
   assign occupancy = state;

   always_comb begin
      state_nxt = state;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt = ONE;
               load_m_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_m_in = 1'b1;
            end else if (in_fire) begin
               state_nxt = FULL;
               load_s    = 1'b1;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_nxt = ONE;
               load_m_s  = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // A flush drops every held entry and any same-cycle input.
      if (flush) begin
         state_nxt = EMPTY;
         load_m_in = 1'b0;
         load_m_s  = 1'b0;
         load_s    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
         m_data     <= '0;
         m_ctrl     <= CTRL_RST;
         s_data     <= '0;
         s_ctrl     <= CTRL_RST;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != FULL);
         if (load_m_in) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
         end else if (load_m_s) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
         end
         if (load_s) begin
            s_data <= in_data;
            s_ctrl <= in_ctrl;
         end
      end
   end

`ifdef PIPE_STAGE_SKID_STATS_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (m_vld && !out_ready) stall_cnt <= stall_cnt + 32'd1;
         if (!m_vld)              bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, counter sequence, random traffic against a queue model.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic [1:0]  occupancy;
`ifdef PIPE_STAGE_SKID_STATS_EN
   logic [31:0] stall_cnt, bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.WIDTH(64), .CTRL_W(8), .CTRL_RST(8'h00)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy)
`ifdef PIPE_STAGE_SKID_STATS_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // Reference: a FIFO of at most two {ctrl,data} entries plus cycle counters.
   logic [71:0] mq[$];
   int unsigned m_stall = 0, m_bubble = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [63:0] d, input logic [7:0] c);
      bit infire, ov;
      rst = r; flush = f; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
      ov     = (mq.size() > 0);
      infire = iv && (mq.size() < 2);
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         if (ov && !ordy) m_stall++;
         if (!ov)         m_bubble++;
         if (f) mq.delete();
         else begin
            if (ov && ordy) void'(mq.pop_front());
            if (infire)     mq.push_back({c, d});
         end
      end
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      logic [71:0] head;
      bit          ov;
      ov   = (mq.size() > 0);
      head = ov ? mq[0] : 72'h0;
      chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
      chk({tag, " in_ready"},  64'(in_ready),  64'(mq.size() < 2));
      chk({tag, " occupancy"}, 64'(occupancy), 64'(mq.size()));
      chk({tag, " out_ctrl"},  64'(out_ctrl),  ov ? 64'(head[71:64]) : 64'h0);
      if (ov) chk({tag, " out_data"}, out_data, head[63:0]);
`ifdef PIPE_STAGE_SKID_STATS_EN
      chk({tag, " stall_cnt"},  64'(stall_cnt),  64'(m_stall));
      chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubble));
`endif
   endtask

   typedef struct {
      logic        r, f, iv, ordy;
      logic [63:0] d;
      logic [7:0]  c;
      logic        ev, chkd;
      logic [63:0] ed;
      logic [7:0]  ec;
      logic        erdy;
      logic [1:0]  eocc;
   } vec_t;

   function automatic vec_t mk(logic r, logic f, logic iv, logic ordy, logic [63:0] d, logic [7:0] c,
                               logic ev, logic chkd, logic [63:0] ed, logic [7:0] ec,
                               logic erdy, logic [1:0] eocc);
      vec_t v;
      v.r = r; v.f = f; v.iv = iv; v.ordy = ordy; v.d = d; v.c = c;
      v.ev = ev; v.chkd = chkd; v.ed = ed; v.ec = ec; v.erdy = erdy; v.eocc = eocc;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      //            r f iv or data    ctrl    ev chkd exp_data exp_ctrl rdy occ
      tbl.push_back(mk(1,0,0,0, 64'h00, 8'h00,  0, 1, 64'h00, 8'h00, 1, 0)); // reset
      tbl.push_back(mk(0,0,1,1, 64'h11, 8'h01,  1, 1, 64'h11, 8'h01, 1, 1)); // stream
      tbl.push_back(mk(0,0,1,1, 64'h22, 8'h02,  1, 1, 64'h22, 8'h02, 1, 1));
      tbl.push_back(mk(0,0,1,1, 64'h33, 8'h03,  1, 1, 64'h33, 8'h03, 1, 1));
      tbl.push_back(mk(0,0,1,1, 64'h44, 8'h04,  1, 1, 64'h44, 8'h04, 1, 1));
      tbl.push_back(mk(0,0,0,1, 64'h00, 8'h00,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,1,0, 64'hA1, 8'hFF,  1, 1, 64'hA1, 8'hFF, 1, 1)); // skid fill
      tbl.push_back(mk(0,0,1,0, 64'hA2, 8'hFE,  1, 1, 64'hA1, 8'hFF, 0, 2));
      tbl.push_back(mk(0,0,0,0, 64'h00, 8'h00,  1, 1, 64'hA1, 8'hFF, 0, 2));
      tbl.push_back(mk(0,0,0,1, 64'h00, 8'h00,  1, 1, 64'hA2, 8'hFE, 1, 1));
      tbl.push_back(mk(0,0,0,1, 64'h00, 8'h00,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,1,0, 64'hC1, 8'hFF,  1, 1, 64'hC1, 8'hFF, 1, 1)); // flush in FULL
      tbl.push_back(mk(0,0,1,0, 64'hC2, 8'hFF,  1, 1, 64'hC1, 8'hFF, 0, 2));
      tbl.push_back(mk(0,1,1,0, 64'hB0, 8'hFF,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,0,0, 64'h00, 8'hFF,  0, 0, 64'h00, 8'h00, 1, 0)); // bubble gating
      tbl.push_back(mk(0,0,0,0, 64'h00, 8'hFF,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,0,0, 64'h00, 8'hFF,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,1,0, 64'hD1, 8'h81,  1, 1, 64'hD1, 8'h81, 1, 1)); // flush kills same-cycle input
      tbl.push_back(mk(0,1,1,1, 64'hD2, 8'h82,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,0,1, 64'h00, 8'h00,  0, 0, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,1,0, 64'hE1, 8'hFF,  1, 1, 64'hE1, 8'hFF, 1, 1)); // reset priority
      tbl.push_back(mk(0,0,1,0, 64'hE2, 8'hFF,  1, 1, 64'hE1, 8'hFF, 0, 2));
      tbl.push_back(mk(1,1,1,0, 64'hE3, 8'hFF,  0, 1, 64'h00, 8'h00, 1, 0));
      tbl.push_back(mk(0,0,1,0, 64'hF1, 8'hAA,  1, 1, 64'hF1, 8'hAA, 1, 1));
      tbl.push_back(mk(0,0,0,1, 64'h00, 8'h00,  0, 0, 64'h00, 8'h00, 1, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, tbl[i].d, tbl[i].c);
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(tbl[i].erdy));
         chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tbl[i].eocc));
         chk($sformatf("vec%0d out_ctrl", i),  64'(out_ctrl),  64'(tbl[i].ec));
         if (tbl[i].chkd) chk($sformatf("vec%0d out_data", i), out_data, tbl[i].ed);
      end

`ifdef PIPE_STAGE_SKID_STATS_EN
      drive(1, 0, 0, 0, 64'h0, 8'h0);
      chk("stats reset stall", 64'(stall_cnt), 64'd0);
      chk("stats reset bubble", 64'(bubble_cnt), 64'd0);
      drive(0, 0, 1, 0, 64'h55, 8'h01);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 64'h0, 8'h0);
      drive(0, 0, 0, 1, 64'h0, 8'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 64'h0, 8'h0);
      chk("stats stall after 5", 64'(stall_cnt), 64'd5);
      chk("stats bubble after 3 empty", 64'(bubble_cnt), 64'd4);
      drive(0, 1, 0, 0, 64'h0, 8'h0);
      chk("stats stall after flush", 64'(stall_cnt), 64'd5);
      chk("stats bubble after flush", 64'(bubble_cnt), 64'd5);
`endif

      drive(1, 0, 0, 0, 64'h0, 8'h0);
      chk_model("rand start");
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
               {$urandom, $urandom}, 8'($urandom_range(0, 255)));
         chk_model($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
